// File: rtl/mult_wb_unit_pkg.sv
// Shared types and defaults for the shift-add multiplier with two-word register-file writeback.
package mult_wb_unit_pkg;
   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 3;
   // Wide enough to hold ITER-1 for the default width, with headroom.
   localparam int CNT_W      = $clog2(DATA_W_DEF) + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CALC  = 2'd1,
      WB_LO = 2'd2,
      WB_HI = 2'd3
   } state_e;
endpackage

// File: rtl/mult_wb_unit_if.sv
// Request / register-file writeback bundle between a requester and mult_wb_unit.
interface mult_wb_unit_if
   import mult_wb_unit_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
);
   logic              start;
   logic [DATA_W-1:0] src1;
   logic [DATA_W-1:0] src2;
   logic [ADDR_W-1:0] dest_reg;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] write_reg;
   logic [DATA_W-1:0] write_data;
   logic              reg_write;

   modport master (
      output start, src1, src2, dest_reg,
      input  busy, done, write_reg, write_data, reg_write
   );

   modport slave (
      input  start, src1, src2, dest_reg,
      output busy, done, write_reg, write_data, reg_write
   );
endinterface

// File: rtl/mult_wb_datapath.sv
// Shift-add datapath: multiplicand, {accumulator, multiplier} shift pair, adder and step counter.
module mult_wb_datapath
   import mult_wb_unit_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ITER   = DATA_W
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                load,
   input  logic                step,
   input  logic [DATA_W-1:0]   src1,
   input  logic [DATA_W-1:0]   src2,
   output logic [2*DATA_W-1:0] product,
   output logic                last
);
   logic [DATA_W-1:0] mcand_q, mcand_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic [DATA_W-1:0] mplier_q, mplier_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] addend;
   logic [DATA_W:0]   sum;

   always_comb begin
      addend   = mplier_q[0] ? mcand_q : '0;
      sum      = {1'b0, acc_q} + {1'b0, addend};
      mcand_d  = mcand_q;
      acc_d    = acc_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      if (load) begin
         mcand_d  = src1;
         mplier_d = src2;
         acc_d    = '0;
         cnt_d    = '0;
      end else if (step) begin
         // Carry drops into the accumulator MSB; retired multiplier bits make room for product low bits.
         acc_d    = sum[DATA_W:1];
         mplier_d = {sum[0], mplier_q[DATA_W-1:1]};
         cnt_d    = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_q  <= '0;
         acc_q    <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
      end else begin
         mcand_q  <= mcand_d;
         acc_q    <= acc_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
      end
   end

   assign product = {acc_q, mplier_q};
   assign last    = (cnt_q == CNT_W'(ITER - 1));
endmodule

// File: rtl/mult_wb_unit.sv
// Unsigned multiplier that writes the double-width product back as two consecutive register words.
module mult_wb_unit
   import mult_wb_unit_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int ITER   = DATA_W
) (
   input  logic          clk,
   input  logic          rst_n,
   mult_wb_unit_if.slave bus
);
   state_e            state_q, state_d;
   logic [ADDR_W-1:0] dest_q, dest_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              reg_write_q, reg_write_d;
   logic [ADDR_W-1:0] write_reg_q, write_reg_d;
   logic [DATA_W-1:0] write_data_q, write_data_d;
   logic              load, step, last;
   logic [2*DATA_W-1:0] product;

   mult_wb_datapath #(.DATA_W(DATA_W), .ITER(ITER)) u_dp (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load),
      .step    (step),
      .src1    (bus.src1),
      .src2    (bus.src2),
      .product (product),
      .last    (last)
   );

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      step    = 1'b0;
      case (state_q)
         IDLE: if (bus.start) begin
            load    = 1'b1;
            state_d = CALC;
         end
         CALC: begin
            step = 1'b1;
            if (last) state_d = WB_LO;
         end
         WB_LO:   state_d = WB_HI;
         WB_HI:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
      dest_d = load ? bus.dest_reg : dest_q;

      // Outputs trail the state by one edge; product is frozen outside CALC.
      busy_d       = (state_d != IDLE);
      done_d       = 1'b0;
      reg_write_d  = 1'b0;
      write_reg_d  = '0;
      write_data_d = '0;
      case (state_q)
         WB_LO: begin
            reg_write_d  = 1'b1;
            write_reg_d  = dest_q;
            write_data_d = product[DATA_W-1:0];
         end
         WB_HI: begin
            reg_write_d  = 1'b1;
            write_reg_d  = dest_q + ADDR_W'(1);
            write_data_d = product[2*DATA_W-1:DATA_W];
            done_d       = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         dest_q       <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         reg_write_q  <= 1'b0;
         write_reg_q  <= '0;
         write_data_q <= '0;
      end else begin
         state_q      <= state_d;
         dest_q       <= dest_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         reg_write_q  <= reg_write_d;
         write_reg_q  <= write_reg_d;
         write_data_q <= write_data_d;
      end
   end

   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.reg_write  = reg_write_q;
   assign bus.write_reg  = write_reg_q;
   assign bus.write_data = write_data_q;
endmodule

// File: tb/tb_mult_wb_unit.sv
// Bench for mult_wb_unit: register-file model, directed table, random operands, busy-start and reset-abort sequences.
module tb_mult_wb_unit;
   logic clk;
   logic rst_n;
   logic rf_clr;
   int   checks   = 0;
   int   failures = 0;
   logic [31:0] rf [8];

   mult_wb_unit_if #(.DATA_W(32), .ADDR_W(3)) bus ();

   mult_wb_unit #(.DATA_W(32), .ADDR_W(3), .ITER(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rf_clr) begin
         for (int i = 0; i < 8; i++) rf[i] <= 32'hA5A5_0000 | i;
      end else if (bus.reg_write === 1'b1) begin
         rf[bus.write_reg] <= bus.write_data;
      end
   end

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  d;
      logic [31:0] lo;
      logic [31:0] hi;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // One full operation; glitch_k > 0 pulses start with fresh operands on that CALC edge.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] d,
                         input int glitch_k);
      logic [63:0] p;
      logic [2:0]  dh;
      int first_rw, n_rw;
      bit busy_ok, quiet_ok, lo_ok, hi_ok, done_ok;
      p  = {32'b0, a} * {32'b0, b};
      dh = d + 3'd1;
      first_rw = -1; n_rw = 0;
      busy_ok = 1; quiet_ok = 1; lo_ok = 0; hi_ok = 0; done_ok = 1;
      @(negedge clk);
      bus.start = 1'b1; bus.src1 = a; bus.src2 = b; bus.dest_reg = d;
      @(posedge clk); #1;
      chk("accept_busy", {63'b0, bus.busy}, 64'd1);
      for (int k = 1; k <= 35; k++) begin
         @(negedge clk);
         bus.start    = (k == glitch_k);
         bus.src1     = $urandom;
         bus.src2     = $urandom;
         bus.dest_reg = 3'($urandom);
         @(posedge clk); #1;
         if (bus.busy !== (k <= 33)) busy_ok = 0;
         if (bus.done !== (k == 34)) done_ok = 0;
         if (bus.reg_write === 1'b1) begin
            n_rw++;
            if (first_rw < 0) first_rw = k;
            if (k == 33) lo_ok = (bus.write_reg === d)  && (bus.write_data === p[31:0]);
            if (k == 34) hi_ok = (bus.write_reg === dh) && (bus.write_data === p[63:32]);
         end else if (bus.write_reg !== 3'd0 || bus.write_data !== 32'd0) begin
            quiet_ok = 0;
         end
      end
      bus.start = 1'b0;
      chk("first_write_latency", 64'(first_rw), 64'd33);
      chk("write_cycles",        64'(n_rw),     64'd2);
      chk("busy_profile",        {63'b0, busy_ok},  64'd1);
      chk("done_pulse",          {63'b0, done_ok},  64'd1);
      chk("idle_outputs_zero",   {63'b0, quiet_ok}, 64'd1);
      chk("wb_lo_bus",           {63'b0, lo_ok},    64'd1);
      chk("wb_hi_bus",           {63'b0, hi_ok},    64'd1);
      chk("rf_lo",               {32'b0, rf[d]},    {32'b0, p[31:0]});
      chk("rf_hi",               {32'b0, rf[dh]},   {32'b0, p[63:32]});
   endtask

   initial begin
      vec_t vt[3];
      logic [31:0] snap [8];
      int n, diffs;
      vt[0] = '{a: 32'd3,          b: 32'd5,          d: 3'd2, lo: 32'd15,         hi: 32'd0};
      vt[1] = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  d: 3'd4, lo: 32'h0000_0001,  hi: 32'hFFFF_FFFE};
      vt[2] = '{a: 32'h8000_0000,  b: 32'd4,          d: 3'd7, lo: 32'h0000_0000,  hi: 32'h0000_0002};

      rst_n = 1'b0; rf_clr = 1'b1;
      bus.start = 1'b0; bus.src1 = '0; bus.src2 = '0; bus.dest_reg = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy",       {63'b0, bus.busy},      64'd0);
      chk("rst_done",       {63'b0, bus.done},      64'd0);
      chk("rst_reg_write",  {63'b0, bus.reg_write}, 64'd0);
      chk("rst_write_reg",  {61'b0, bus.write_reg}, 64'd0);
      chk("rst_write_data", {32'b0, bus.write_data}, 64'd0);
      @(negedge clk); rst_n = 1'b1; rf_clr = 1'b0;

      for (int i = 0; i < 3; i++) begin
         run_op(vt[i].a, vt[i].b, vt[i].d, 0);
         chk("table_lo", {32'b0, rf[vt[i].d]},         {32'b0, vt[i].lo});
         chk("table_hi", {32'b0, rf[3'(vt[i].d + 1)]}, {32'b0, vt[i].hi});
      end

      for (int i = 0; i < 5; i++) run_op($urandom, $urandom, 3'($urandom), 0);

      // Second request mid-computation must be dropped.
      run_op(32'h1234_5678, 32'h9ABC_DEF0, 3'd1, 10);
      n = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (bus.reg_write === 1'b1 || bus.busy === 1'b1) n++;
      end
      chk("glitch_not_accepted", 64'(n), 64'd0);

      // Reset 20 cycles into CALC aborts without any write.
      @(negedge clk);
      bus.start = 1'b1; bus.src1 = 32'hDEAD_BEEF; bus.src2 = 32'h0000_0777; bus.dest_reg = 3'd6;
      @(posedge clk);
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk); bus.start = 1'b0;
         @(posedge clk);
      end
      @(negedge clk);
      for (int i = 0; i < 8; i++) snap[i] = rf[i];
      rst_n = 1'b0;
      #1;
      chk("abort_busy",      {63'b0, bus.busy},      64'd0);
      chk("abort_reg_write", {63'b0, bus.reg_write}, 64'd0);
      chk("abort_done",      {63'b0, bus.done},      64'd0);
      repeat (3) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      n = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (bus.reg_write === 1'b1) n++;
      end
      chk("no_write_after_abort", 64'(n), 64'd0);
      diffs = 0;
      for (int i = 0; i < 8; i++) if (rf[i] !== snap[i]) diffs++;
      chk("rf_untouched_by_abort", 64'(diffs), 64'd0);
      run_op(32'h0001_0003, 32'h0002_0005, 3'd6, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mult_wb_unit.md
MULT_WB_UNIT -- requirements
Module: mult_wb_unit

Interface
REQ-001 Parameter: DATA_W, 32, operand and register-file data width.
REQ-002 Parameter: ADDR_W, 3, register-file address width (8 registers).
REQ-003 Parameter: ITER, DATA_W, number of shift-add iterations.
REQ-004 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 Port: start  input  1  request; sampled only in IDLE.
REQ-007 Port: src1  input  DATA_W  multiplicand, from register-file read_data1.
REQ-008 Port: src2  input  DATA_W  multiplier, from register-file read_data2.
REQ-009 Port: dest_reg  input  ADDR_W  destination register for the low product word.
REQ-010 Port: busy  output  1  high in every state except IDLE.
REQ-011 Port: done  output  1  one-cycle pulse during WB_HI.
REQ-012 Port: write_reg  output  ADDR_W  register-file write address.
REQ-013 Port: write_data  output  DATA_W  register-file write data.
REQ-014 Port: reg_write  output  1  register-file write enable.

Function
REQ-015 The block SHALL compute the unsigned 2*DATA_W-bit product src1*src2 and write it back to the register file as two words.
REQ-016 FSM states SHALL be IDLE, CALC, WB_LO, WB_HI.
REQ-017 IDLE with start=1 at a rising edge: latch src1, src2, dest_reg; clear accumulator and iteration counter; go to CALC.
REQ-018 IDLE with start=0: remain in IDLE; reg_write=0, done=0.
REQ-019 CALC: each cycle, if multiplier LSB=1 add multiplicand to accumulator upper half (DATA_W+1-bit sum keeps the carry), then shift {carry, accumulator, multiplier} right by one; counter increments.
REQ-020 CALC SHALL last exactly ITER cycles; after the ITER-th CALC edge, go to WB_LO.
REQ-021 WB_LO (one cycle): reg_write=1, write_reg=latched dest, write_data=product[DATA_W-1:0]; go to WB_HI.
REQ-022 WB_HI (one cycle): reg_write=1, write_reg=(latched dest+1) mod 2^ADDR_W, write_data=product[2*DATA_W-1:DATA_W], done=1; go to IDLE.
REQ-023 Latency: after the accepting edge, reg_write first goes high 33 edges later; the next request can be accepted on the 35th edge after the accepting edge.
REQ-024 start while busy=1 SHALL be ignored; latched operands and dest SHALL NOT change.
REQ-025 dest_reg=7 SHALL place the high word in register 0 (wrap-around).
REQ-026 All outputs SHALL be registered; in IDLE and CALC reg_write=0, write_reg=0, write_data=0.
REQ-027 src1/src2/dest_reg changes after the accepting edge SHALL NOT affect the result.

Reset
REQ-028 rst_n=0 SHALL immediately force state=IDLE and busy, done, reg_write, write_reg, write_data, accumulator and counter to 0.
REQ-029 Reset in any non-IDLE state SHALL abort the operation with no further register-file write.
REQ-030 After rst_n returns to 1, the first rising edge with start=1 SHALL be accepted normally.

Structure
REQ-031 Shared package SHALL hold the FSM state encoding, DATA_W and ADDR_W defaults, and the iteration-counter width.
REQ-032 One sub-module, mult_wb_datapath (accumulator, multiplier shift register, adder, counter), SHALL be instantiated; FSM and output registers stay in mult_wb_unit.

Verification
REQ-033 src1=3, src2=5, dest=2, start pulse -> WB_LO writes 15 to reg 2; WB_HI writes 0 to reg 3 with done=1.
REQ-034 src1=src2=0xFFFFFFFF, dest=4 -> reg 4 gets 0x00000001, reg 5 gets 0xFFFFFFFE.
REQ-035 dest=7, src1=0x80000000, src2=4 -> reg 7 gets 0x00000000, reg 0 gets 0x00000002.
REQ-036 Second start and changed src1/src2 pulsed 10 cycles into CALC -> ignored; first result unchanged; busy stays high throughout.
REQ-037 rst_n low 20 cycles into CALC -> busy=0 and reg_write=0 immediately; no write follows; a new request after release yields a correct result.
REQ-038 Bench SHALL drive mult_wb_unit into a register-file model and check contents after each operation, plus reg_write high for exactly 2 cycles per operation.
